// File: rtl/dual_stream_line_scheduler_pkg.sv
// Shared definitions for the dual-stream line scheduler: FSM encoding,
// the vsync edge pattern and the counter width helper.
package dual_stream_line_scheduler_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_PAIR = 3'd1;
    localparam state_t ST_READ_LINE = 3'd2;
    localparam state_t ST_H_BLANK   = 3'd3;
    localparam state_t ST_V_BLANK   = 3'd4;

    // {current, previous} sample of the slave vsync that marks a rising edge
    localparam logic [1:0] SYNC_RISE = 2'b10;

    // Bits needed for a counter running 0..n-1 (never less than one bit)
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/align_term_counter.sv
// Up-counter with synchronous clear and a terminal-count pulse.
// Used for the pixel counter, the blanking counter and the stall timer.
module align_term_counter #(
    parameter int P_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [P_WIDTH-1:0] term,
    output logic               tc
);

    logic [P_WIDTH-1:0] cnt;

    // Clear has priority over counting; the count never wraps inside a use
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Pulse on the cycle the counter sits on its terminal value while enabled
    assign tc = en & ~load & (cnt == term);

endmodule

// File: rtl/dual_stream_line_scheduler.sv
// Read-side sequencer for the master/slave line-FIFO alignment path.
// Waits until both FIFOs hold a full line, issues one read burst per line,
// regenerates aligned H/V sync and abandons frames where one stream stalls.
module dual_stream_line_scheduler
    import dual_stream_line_scheduler_pkg::*;
#(
    parameter int P_IMAGE_WIDTH  = 256,
    parameter int P_IMAGE_HEIGHT = 256,
    parameter int P_LVL_WIDTH    = 10,
    parameter int P_HBLANK       = 16,
    parameter int P_VBLANK       = 64,
    parameter int P_TIMEOUT      = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_v_aync_s,
    input  logic [P_LVL_WIDTH-1:0] i_lvl_m,
    input  logic [P_LVL_WIDTH-1:0] i_lvl_s,
    output logic                   o_rd_en,
    output logic                   o_h_aync,
    output logic                   o_v_aync,
    output logic [15:0]            o_line_cnt,
    output logic                   o_busy,
    output logic                   o_timeout,
    output logic [7:0]             o_err_cnt
);

    localparam int BLK_MAX = (P_HBLANK > P_VBLANK) ? P_HBLANK : P_VBLANK;
    localparam int PIX_W   = cnt_w(P_IMAGE_WIDTH);
    localparam int BLK_W   = cnt_w(BLK_MAX);
    localparam int STALL_W = cnt_w(P_TIMEOUT);

    // The WAIT_PAIR sampling cycle is the last cycle of the line gap, so
    // H_BLANK itself only needs P_HBLANK-1 cycles (none when P_HBLANK is 1).
    localparam bit HB_STATE = (P_HBLANK > 1);

    localparam logic [P_LVL_WIDTH:0] LINE_LVL   = (P_LVL_WIDTH+1)'(P_IMAGE_WIDTH);
    localparam logic [PIX_W-1:0]     PIX_LAST   = PIX_W'(P_IMAGE_WIDTH - 1);
    localparam logic [BLK_W-1:0]     HB_LAST    = BLK_W'(HB_STATE ? P_HBLANK - 2 : 0);
    localparam logic [BLK_W-1:0]     VB_LAST    = BLK_W'(P_VBLANK - 1);
    localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(P_TIMEOUT - 1);
    localparam logic [15:0]          LAST_LINE  = 16'(P_IMAGE_HEIGHT - 1);

    state_t             state;
    state_t             state_nxt;
    logic               vs_prev;
    logic               vs_rise;
    logic               frame_start;
    logic               m_rdy;
    logic               s_rdy;
    logic               pair_rdy;
    logic               one_rdy;
    logic               stall_en;
    logic               blank_en;
    logic               pix_tc;
    logic               blk_tc;
    logic               stall_tc;
    logic [BLK_W-1:0]   blk_term;

    assign vs_rise     = ({i_v_aync_s, vs_prev} == SYNC_RISE);
    assign frame_start = (state == ST_IDLE) && vs_rise && i_enable;

    // Levels are only looked at in WAIT_PAIR; a burst never re-checks them
    assign m_rdy    = ({1'b0, i_lvl_m} >= LINE_LVL);
    assign s_rdy    = ({1'b0, i_lvl_s} >= LINE_LVL);
    assign pair_rdy = m_rdy & s_rdy;
    assign one_rdy  = m_rdy ^ s_rdy;

    assign stall_en = (state == ST_WAIT_PAIR) && one_rdy;
    assign blank_en = (state == ST_H_BLANK) || (state == ST_V_BLANK);
    assign blk_term = (state == ST_V_BLANK) ? VB_LAST : HB_LAST;

    assign o_busy   = (state != ST_IDLE);

    align_term_counter #(.P_WIDTH(PIX_W)) u_pix_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (state != ST_READ_LINE),
        .en      (state == ST_READ_LINE),
        .term    (PIX_LAST),
        .tc      (pix_tc)
    );

    align_term_counter #(.P_WIDTH(BLK_W)) u_blk_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (~blank_en),
        .en      (blank_en),
        .term    (blk_term),
        .tc      (blk_tc)
    );

    // Stall timer only runs while exactly one stream has a line ready
    align_term_counter #(.P_WIDTH(STALL_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (~stall_en),
        .en      (stall_en),
        .term    (STALL_LAST),
        .tc      (stall_tc)
    );

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (frame_start) state_nxt = ST_WAIT_PAIR;
            ST_WAIT_PAIR:
                if (pair_rdy)      state_nxt = ST_READ_LINE;
                else if (stall_tc) state_nxt = ST_IDLE;
            ST_READ_LINE:
                if (pix_tc) begin
                    if (o_line_cnt < LAST_LINE)
                        state_nxt = HB_STATE ? ST_H_BLANK : ST_WAIT_PAIR;
                    else
                        state_nxt = ST_V_BLANK;
                end
            ST_H_BLANK:
                if (blk_tc) state_nxt = ST_WAIT_PAIR;
            ST_V_BLANK:
                if (blk_tc) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // State register and vsync history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            vs_prev <= 1'b0;
        end else begin
            state   <= state_nxt;
            vs_prev <= i_v_aync_s;
        end
    end

    // Read enable tracks READ_LINE; syncs follow one cycle behind the FIFO read
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_en  <= 1'b0;
            o_h_aync <= 1'b0;
            o_v_aync <= 1'b0;
        end else begin
            o_rd_en  <= (state_nxt == ST_READ_LINE);
            o_h_aync <= o_rd_en;
            if (o_rd_en)
                o_v_aync <= 1'b1;
            else if ((state == ST_V_BLANK) && o_h_aync)
                o_v_aync <= 1'b0;
            else if (state == ST_IDLE)
                o_v_aync <= 1'b0;
        end
    end

    // Frame bookkeeping: line count, sticky stall flag, saturating abandon count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_line_cnt <= '0;
            o_timeout  <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            if (frame_start) begin
                o_line_cnt <= '0;
                o_timeout  <= 1'b0;
            end else if ((state == ST_READ_LINE) && pix_tc) begin
                o_line_cnt <= o_line_cnt + 16'd1;
            end
            if ((state == ST_WAIT_PAIR) && !pair_rdy && stall_tc) begin
                o_timeout <= 1'b1;
                if (o_err_cnt != 8'hFF)
                    o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dual_stream_line_scheduler.sv
// Scoreboard bench: the stimulus pushes the expected read bursts of each frame,
// a negedge monitor measures every burst (length, gap, sync alignment) and
// compares against the queue; status outputs are checked from the stimulus.
module tb_dual_stream_line_scheduler;

    typedef struct {
        int len;
        int gap;   // idle cycles before the burst, -1 = first of frame
    } burst_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        vsync;
    logic [9:0]  lvl_m;
    logic [9:0]  lvl_s;
    logic        rd_en;
    logic        h_sync;
    logic        v_sync;
    logic [15:0] line_cnt;
    logic        busy;
    logic        timeout;
    logic [7:0]  err_cnt;

    int     total = 0;
    int     bad   = 0;
    burst_t exp_q[$];
    burst_t e;
    bit     p_rd, p_h, p_v;
    int     run_len, lag_bad, start_gap, gap_cnt;

    dual_stream_line_scheduler #(
        .P_IMAGE_WIDTH  (8),
        .P_IMAGE_HEIGHT (4),
        .P_LVL_WIDTH    (10),
        .P_HBLANK       (2),
        .P_VBLANK       (3),
        .P_TIMEOUT      (20)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_v_aync_s (vsync),
        .i_lvl_m    (lvl_m),
        .i_lvl_s    (lvl_s),
        .o_rd_en    (rd_en),
        .o_h_aync   (h_sync),
        .o_v_aync   (v_sync),
        .o_line_cnt (line_cnt),
        .o_busy     (busy),
        .o_timeout  (timeout),
        .o_err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int gap2);
        exp_q.push_back('{8, -1});
        exp_q.push_back('{8, gap2});
        exp_q.push_back('{8, 2});
        exp_q.push_back('{8, 2});
    endtask

    // Ticks until busy falls; n = ticks taken (bounded)
    task automatic wait_busy_low(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Monitor: measure each rd_en burst and its sync alignment
    always @(negedge clk) begin
        if (rd_en) begin
            if (!p_rd) begin
                run_len   = 0;
                lag_bad   = 0;
                start_gap = gap_cnt;
            end
            run_len++;
            if (h_sync !== p_rd) lag_bad++;
            if (h_sync && !v_sync) lag_bad++;
        end else if (p_rd) begin
            if (rst_n && h_sync !== 1'b1) lag_bad++;
            if (exp_q.size() == 0) begin
                check("burst_unexpected", run_len, 0);
            end else begin
                e = exp_q.pop_front();
                check("burst_len", run_len, e.len);
                if (e.gap >= 0) check("burst_gap", start_gap, e.gap);
                check("burst_sync_align", lag_bad, 0);
            end
            gap_cnt = 1;
        end else begin
            gap_cnt++;
        end
        if (v_sync && !p_v) check("vsync_rise_with_first_h", int'(h_sync) * 2 + int'(p_h), 2);
        if (!v_sync && p_v) check("vsync_fall_after_last_h", int'(p_h) * 2 + int'(h_sync), 2);
        p_rd = rd_en;
        p_h  = h_sync;
        p_v  = v_sync;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        enable = 1'b1;
        vsync  = 1'b0;
        lvl_m  = 10'd0;
        lvl_s  = 10'd0;
        repeat (3) tick();

        // Reset state
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_v_sync", int'(v_sync), 0);
        rst_n = 1'b1;
        tick();
        check("rst_line_cnt", int'(line_cnt), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_timeout", int'(timeout), 0);

        // 1. Full frame with both FIFOs ready
        lvl_m = 10'd8;
        lvl_s = 10'd8;
        push_frame(2);
        vsync = 1'b1;                      // T0
        tick();                            // T1
        check("t1_busy_start", int'(busy), 1);
        check("t1_rd_not_yet", int'(rd_en), 0);
        tick();                            // T2
        check("t1_rd_first", int'(rd_en), 1);
        vsync = 1'b0;
        wait_busy_low(100, n);
        check("t1_busy_drop_cycle", 2 + n, 43);
        check("t1_line_cnt", int'(line_cnt), 4);
        check("t1_err_cnt", int'(err_cnt), 0);

        // 2. Slave never ready -> stall timeout
        lvl_s = 10'd0;
        tick();
        vsync = 1'b1;                      // T0
        tick();                            // T1: in WAIT_PAIR
        check("t2_busy_start", int'(busy), 1);
        vsync = 1'b0;
        n = 0;
        while (!timeout && n < 100) begin
            tick();
            n++;
        end
        check("t2_timeout_latency", n, 20);
        check("t2_err_cnt", int'(err_cnt), 1);
        check("t2_back_idle", int'(busy), 0);

        // 3. Slave arrives on stall cycle 10; second line stalls 15 cycles
        push_frame(17);
        tick();
        vsync = 1'b1;                      // T0
        tick();                            // T1
        check("t3_timeout_cleared", int'(timeout), 0);
        vsync = 1'b0;
        repeat (10) tick();                // T11
        check("t3_rd_before_pair", int'(rd_en), 0);
        lvl_s = 10'd8;
        tick();                            // T12
        check("t3_rd_after_pair", int'(rd_en), 1);
        lvl_s = 10'd0;
        repeat (24) tick();                // T36
        check("t3_rd_stalled", int'(rd_en), 0);
        check("t3_no_timeout_mid", int'(timeout), 0);
        lvl_s = 10'd8;
        tick();                            // T37
        check("t3_rd_resume", int'(rd_en), 1);
        wait_busy_low(100, n);
        check("t3_busy_drop_cycle", 37 + n, 68);
        check("t3_no_timeout", int'(timeout), 0);
        check("t3_err_cnt", int'(err_cnt), 1);
        check("t3_line_cnt", int'(line_cnt), 4);

        // 4. Second vsync rise mid-frame is ignored
        push_frame(2);
        tick();
        vsync = 1'b1;                      // T0
        tick();                            // T1
        tick();                            // T2
        vsync = 1'b0;
        repeat (13) tick();                // T15
        vsync = 1'b1;
        wait_busy_low(100, n);
        check("t4_busy_drop_cycle", 15 + n, 43);
        repeat (10) tick();
        check("t4_stays_idle", int'(busy), 0);
        check("t4_line_cnt", int'(line_cnt), 4);
        check("t4_err_cnt", int'(err_cnt), 1);
        vsync = 1'b0;
        tick();

        // 5. Asynchronous reset during burst cycle 3
        exp_q.push_back('{2, -1});
        vsync = 1'b1;                      // T0
        tick();                            // T1
        tick();                            // T2
        vsync = 1'b0;
        tick();                            // T3
        tick();                            // T4: third read cycle
        rst_n = 1'b0;
        #1;
        check("t5_rd_async", int'(rd_en), 0);
        check("t5_h_async", int'(h_sync), 0);
        check("t5_v_async", int'(v_sync), 0);
        check("t5_busy_async", int'(busy), 0);
        check("t5_err_cleared", int'(err_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_idle_after_rst", int'(busy), 0);
        push_frame(2);
        vsync = 1'b1;                      // T0
        tick();                            // T1
        tick();                            // T2
        vsync = 1'b0;
        wait_busy_low(100, n);
        check("t5_clean_frame_drop", 2 + n, 43);
        check("t5_line_cnt", int'(line_cnt), 4);

        // 6. Saturate the abandon counter, then vsync with enable low
        lvl_m = 10'd8;
        lvl_s = 10'd0;
        tick();
        for (int i = 0; i < 256; i++) begin
            vsync = 1'b1;
            tick();
            vsync = 1'b0;
            wait_busy_low(40, n);
            tick();
            if (i == 254) check("t6_err_at_255", int'(err_cnt), 255);
        end
        check("t6_err_saturated", int'(err_cnt), 255);
        check("t6_timeout_set", int'(timeout), 1);
        enable = 1'b0;
        vsync  = 1'b1;
        tick();
        tick();
        check("t6_disabled_idle", int'(busy), 0);
        repeat (5) tick();
        check("t6_disabled_still_idle", int'(busy), 0);
        check("t6_timeout_kept", int'(timeout), 1);
        vsync = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
